// File: rtl/click_mux_n_sync.sv
// rtl/click_mux_n_sync.sv - N-way clocked two-phase click mux with early-acknowledged select channel
module click_mux_n_sync #(
  parameter int           N              = 4,
  parameter int           W              = 8,
  parameter int           SW             = $clog2(N),
  parameter int           CNT_W          = 16,
  parameter logic [N-1:0] PHASE_INIT_IN  = '0,
  parameter logic         PHASE_INIT_OUT = 1'b0,
  parameter logic         PHASE_INIT_SEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_req,
  output logic [N-1:0]     in_ack,
  input  logic [N*W-1:0]   in_data,
  input  logic             sel_req,
  output logic             sel_ack,
  input  logic [SW-1:0]    sel_data,
  output logic             out_req,
  input  logic             out_ack,
  output logic [W-1:0]     out_data,
  output logic             err,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic {IDLE, ARMED} state_t;

  // Channel count widened by one bit so sel_data >= N is detectable when N is not a power of two
  localparam logic [SW:0] N_LIM = (SW+1)'(N);

  state_t        state, state_d;
  logic [SW-1:0] sel_q;
  logic [W-1:0]  in_arr [N];
  logic          sel_pending, sel_valid, in_pending, out_free;
  logic          take_sel, drop_sel, fire;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign in_arr[gi] = in_data[gi*W +: W];
  end

  assign sel_pending = (sel_req != sel_ack);
  assign sel_valid   = ({1'b0, sel_data} < N_LIM);
  assign in_pending  = (in_req[sel_q] != in_ack[sel_q]);
  assign out_free    = (out_req == out_ack);

  // Next-state and per-edge action decode: consume/drop a select in IDLE, fire in ARMED
  always_comb begin
    state_d  = state;
    take_sel = 1'b0;
    drop_sel = 1'b0;
    fire     = 1'b0;
    case (state)
      IDLE: begin
        if (sel_pending) begin
          if (sel_valid) begin
            take_sel = 1'b1;
            state_d  = ARMED;
          end else begin
            drop_sel = 1'b1;
          end
        end
      end
      ARMED: begin
        if (in_pending && out_free) begin
          fire    = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Handshake phases, latched select, output data, sticky error and transfer counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ack     <= PHASE_INIT_IN;
      sel_ack    <= PHASE_INIT_SEL;
      out_req    <= PHASE_INIT_OUT;
      out_data   <= '0;
      err        <= 1'b0;
      xfer_count <= '0;
      sel_q      <= '0;
    end else begin
      if (take_sel) begin
        sel_q <= sel_data;
      end
      if (take_sel || drop_sel) begin
        sel_ack <= ~sel_ack;
      end
      if (drop_sel) begin
        err <= 1'b1;
      end
      if (fire) begin
        out_data      <= in_arr[sel_q];
        out_req       <= ~out_req;
        in_ack[sel_q] <= ~in_ack[sel_q];
        xfer_count    <= xfer_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_click_mux_n_sync.sv
// tb/tb_click_mux_n_sync.sv - self-checking bench for click_mux_n_sync (N=4 main instance, N=3/CNT_W=2 instance)
module tb_click_mux_n_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic        a_rst;
  logic [3:0]  a_in_req, a_in_ack;
  logic [31:0] a_in_data;
  logic        a_sel_req, a_sel_ack;
  logic [1:0]  a_sel_data;
  logic        a_out_req, a_out_ack;
  logic [7:0]  a_out_data;
  logic        a_err;
  logic [15:0] a_cnt;

  logic        b_rst;
  logic [2:0]  b_in_req, b_in_ack;
  logic [23:0] b_in_data;
  logic        b_sel_req, b_sel_ack;
  logic [1:0]  b_sel_data;
  logic        b_out_req, b_out_ack;
  logic [7:0]  b_out_data;
  logic        b_err;
  logic [1:0]  b_cnt;

  click_mux_n_sync #(.N(4), .W(8), .CNT_W(16)) u_a (
    .clk(clk), .rst(a_rst),
    .in_req(a_in_req), .in_ack(a_in_ack), .in_data(a_in_data),
    .sel_req(a_sel_req), .sel_ack(a_sel_ack), .sel_data(a_sel_data),
    .out_req(a_out_req), .out_ack(a_out_ack), .out_data(a_out_data),
    .err(a_err), .xfer_count(a_cnt)
  );

  click_mux_n_sync #(.N(3), .W(8), .CNT_W(2)) u_b (
    .clk(clk), .rst(b_rst),
    .in_req(b_in_req), .in_ack(b_in_ack), .in_data(b_in_data),
    .sel_req(b_sel_req), .sel_ack(b_sel_ack), .sel_data(b_sel_data),
    .out_req(b_out_req), .out_ack(b_out_ack), .out_data(b_out_data),
    .err(b_err), .xfer_count(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int          consumed [4];
  int          exp_cnt;
  int          ch;
  logic [7:0]  d;
  logic        prev;
  logic [3:0]  exp_ack;
  logic [7:0]  got [$];
  int          sel_list [3];
  int          wrap_exp [5];

  initial begin
    a_rst = 1'b0; a_in_req = '0; a_in_data = '0; a_sel_req = 1'b0; a_sel_data = '0; a_out_ack = 1'b0;
    b_rst = 1'b0; b_in_req = '0; b_in_data = '0; b_sel_req = 1'b0; b_sel_data = '0; b_out_ack = 1'b0;
    #2;
    check("rst_a_in_ack",   a_in_ack,   0);
    check("rst_a_sel_ack",  a_sel_ack,  0);
    check("rst_a_out_req",  a_out_req,  0);
    check("rst_a_out_data", a_out_data, 0);
    check("rst_a_err",      a_err,      0);
    check("rst_a_cnt",      a_cnt,      0);
    check("rst_b_err",      b_err,      0);
    check("rst_b_cnt",      b_cnt,      0);
    tick(1);
    a_rst = 1'b1;
    b_rst = 1'b1;

    // basic transfer on channel 2
    a_in_data[23:16] = 8'hA5;
    a_in_req[2]      = ~a_in_req[2];
    a_sel_data       = 2'd2;
    a_sel_req        = ~a_sel_req;
    tick(1);
    check("t1_sel_ack_e1", a_sel_ack, 1);
    check("t1_out_req_e1", a_out_req, 0);
    tick(1);
    check("t1_out_req_e2",  a_out_req,  1);
    check("t1_out_data_e2", a_out_data, 8'hA5);
    check("t1_in_ack_e2",   a_in_ack,   4'b0100);
    check("t1_cnt",         a_cnt,      1);

    // output stall with out_ack held, then release
    a_in_data[15:8] = 8'h3C;
    a_in_req[1]     = ~a_in_req[1];
    a_sel_data      = 2'd1;
    a_sel_req       = ~a_sel_req;
    tick(1);
    check("t2_sel_ack", a_sel_ack, 0);
    tick(3);
    check("t2_stall_data",    a_out_data, 8'hA5);
    check("t2_stall_in_ack",  a_in_ack,   4'b0100);
    check("t2_stall_out_req", a_out_req,  1);
    check("t2_stall_cnt",     a_cnt,      1);
    a_out_ack = 1'b1;
    tick(1);
    check("t2_rel_data",    a_out_data, 8'h3C);
    check("t2_rel_in_ack",  a_in_ack,   4'b0110);
    check("t2_rel_out_req", a_out_req,  0);
    check("t2_rel_cnt",     a_cnt,      2);
    a_out_ack = 1'b0;

    // several pending inputs served in select order
    a_in_data[7:0]   = 8'h11;
    a_in_data[15:8]  = 8'h22;
    a_in_data[31:24] = 8'h33;
    a_in_req         = a_in_req ^ 4'b1011;
    sel_list         = '{3, 0, 1};
    foreach (sel_list[i]) begin
      a_sel_data = 2'(sel_list[i]);
      a_sel_req  = ~a_sel_req;
      for (int k = 0; k < 10 && a_out_req === a_out_ack; k++) tick(1);
      got.push_back(a_out_data);
      a_out_ack = a_out_req;
    end
    check("t3_first",  got[0], 8'h33);
    check("t3_second", got[1], 8'h11);
    check("t3_third",  got[2], 8'h22);
    check("t3_in_ack", a_in_ack, 4'b1101);
    check("t3_cnt",    a_cnt,    5);

    // randomized transfers against a token-count model, with random output back-pressure
    consumed = '{1, 2, 1, 1};
    exp_cnt  = 5;
    for (int it = 0; it < 40; it++) begin
      ch = $urandom_range(0, 3);
      d  = 8'($urandom);
      a_in_data[ch*8 +: 8] = d;
      a_in_req[ch]         = ~a_in_req[ch];
      a_sel_data           = 2'(ch);
      a_sel_req            = ~a_sel_req;
      prev                 = a_out_req;
      tick($urandom_range(0, 3));
      a_out_ack = a_out_req;
      for (int k = 0; k < 20 && a_out_req === prev; k++) tick(1);
      consumed[ch]++;
      exp_cnt++;
      for (int i = 0; i < 4; i++) exp_ack[i] = consumed[i][0];
      check("rnd_out_req",  a_out_req,  !prev);
      check("rnd_out_data", a_out_data, d);
      check("rnd_in_ack",   a_in_ack,   exp_ack);
      check("rnd_cnt",      a_cnt,      exp_cnt);
      check("rnd_sel_ack",  a_sel_ack,  a_sel_req);
    end
    a_out_ack = a_out_req;
    tick(1);
    check("rnd_err", a_err, 0);

    // asynchronous reset while ARMED on a non-pending channel
    a_sel_data = 2'd2;
    a_sel_req  = ~a_sel_req;
    prev       = a_out_req;
    tick(1);
    check("ar_armed_sel_ack", a_sel_ack, a_sel_req);
    tick(2);
    check("ar_armed_hold", a_out_req, prev);
    #3;
    a_rst = 1'b0;
    #1;
    check("ar_in_ack",   a_in_ack,   0);
    check("ar_sel_ack",  a_sel_ack,  0);
    check("ar_out_req",  a_out_req,  0);
    check("ar_out_data", a_out_data, 0);
    check("ar_err",      a_err,      0);
    check("ar_cnt",      a_cnt,      0);
    a_in_req  = '0;
    a_sel_req = 1'b0;
    a_out_ack = 1'b0;
    tick(1);
    a_rst = 1'b1;
    a_in_data[23:16] = 8'h5A;
    a_in_req[2]      = 1'b1;
    tick(4);
    check("ar_nofire_out_req", a_out_req, 0);
    check("ar_nofire_in_ack",  a_in_ack,  0);
    check("ar_nofire_cnt",     a_cnt,     0);
    a_sel_data = 2'd2;
    a_sel_req  = 1'b1;
    tick(2);
    check("ar_fire_out_req",  a_out_req,  1);
    check("ar_fire_out_data", a_out_data, 8'h5A);
    check("ar_fire_in_ack",   a_in_ack,   4'b0100);
    check("ar_fire_cnt",      a_cnt,      1);

    // out-of-range select on the N=3 instance
    b_sel_data = 2'd3;
    b_sel_req  = 1'b1;
    tick(1);
    check("oor_sel_ack", b_sel_ack, 1);
    check("oor_err",     b_err,     1);
    tick(1);
    check("oor_out_req",    b_out_req, 0);
    check("oor_cnt",        b_cnt,     0);
    check("oor_sel_ack_st", b_sel_ack, 1);

    // valid transfers after the dropped select, counter wraps at 2 bits
    wrap_exp = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      ch = $urandom_range(0, 2);
      d  = 8'($urandom);
      b_in_data[ch*8 +: 8] = d;
      b_in_req[ch]         = ~b_in_req[ch];
      b_sel_data           = 2'(ch);
      b_sel_req            = ~b_sel_req;
      prev                 = b_out_req;
      for (int k = 0; k < 10 && b_out_req === prev; k++) tick(1);
      check("wrap_out_req",  b_out_req,  !prev);
      check("wrap_out_data", b_out_data, d);
      check("wrap_cnt",      b_cnt,      wrap_exp[i]);
      b_out_ack = b_out_req;
    end
    check("wrap_err_sticky", b_err, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
